// File: rtl/muldiv_if.sv
// Handshake and HI/LO bundle between the EX stage and the mul/div sequencer.
interface muldiv_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] busA;
  logic [WIDTH-1:0] busB;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, busA, busB,
    output hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, busA, busB,
    input  hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// Bit-serial MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic   clk,
  input logic   rst,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP
  } state_e;

  state_e             state_q, state_d;
  logic               div_q, div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               dz_q, dz_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   md_q, md_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dzo_q, dzo_d;

  logic               st_div;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   quo_f;
  logic [WIDTH-1:0]   rem_f;

  assign st_div = bus.op[1];
  assign a_neg  = bus.op[0] & bus.busA[WIDTH-1];
  assign b_neg  = bus.op[0] & bus.busB[WIDTH-1];
  assign a_mag  = a_neg ? -bus.busA : bus.busA;
  assign b_mag  = b_neg ? -bus.busB : bus.busB;

  assign mul_sum = {1'b0, acc_q}
                 + (mq_q[0] ? {1'b0, md_q} : '0);
  assign shl     = {acc_q, mq_q[WIDTH-1]};
  assign trial   = shl - {1'b0, md_q};

  // sa/sb already fold in signedness, so unsigned ops never negate
  assign prod   = {acc_q, mq_q};
  assign prod_f = (sa_q ^ sb_q) ? -prod : prod;
  assign quo_f  = (sa_q ^ sb_q) ? -mq_q : mq_q;
  assign rem_f  = sa_q ? -acc_q : acc_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    md_d    = md_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dzo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          div_d  = st_div;
          sa_d   = a_neg;
          sb_d   = b_neg;
          acc_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          mq_d   = st_div ? a_mag : b_mag;
          md_d   = st_div ? b_mag : a_mag;
          dz_d   = st_div && (bus.busB == '0);
          state_d = (st_div && (bus.busB == '0))
                  ? FIXUP : CALC;
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (div_q) begin
          mq_d = {mq_q[WIDTH-2:0], ~trial[WIDTH]};
          acc_d = trial[WIDTH] ? shl[WIDTH-1:0]
                               : trial[WIDTH-1:0];
        end else begin
          acc_d = mul_sum[WIDTH:1];
          mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH-1))
          state_d = FIXUP;
      end
      FIXUP: begin
        if (dz_q) begin
          dzo_d = 1'b1;
        end else if (div_q) begin
          hi_d = rem_f;
          lo_d = quo_f;
        end else begin
          hi_d = prod_f[2*WIDTH-1:WIDTH];
          lo_d = prod_f[WIDTH-1:0];
        end
        dz_d    = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      md_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      md_q    <= md_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dzo_q   <= dzo_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dzo_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed checks of muldiv_seq against an arithmetic model.
module tb_muldiv_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: returns {hi, lo}
  function automatic logic [63:0] model(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (op)
      2'b00: res = {32'b0, a} * {32'b0, b};
      2'b01: begin
        p = sa * sb;
        res = p;
      end
      2'b10: res = {a % b, a / b};
      default: begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
    endcase
    return res;
  endfunction

  task automatic run_op(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          cyc,
    output int          bcnt
  );
    bus.op    = op;
    bus.busA  = a;
    bus.busB  = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.busA  = $urandom;
    bus.busB  = $urandom;
    cyc  = 0;
    bcnt = bus.busy ? 1 : 0;
    while (!bus.done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!bus.done && bus.busy) bcnt++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL timeout op=%0d got no done", op);
    end
  endtask

  task automatic check_res(
    input string       name,
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input int          cyc
  );
    logic [63:0] exp;
    exp = model(op, a, b);
    checks++;
    if (bus.hi !== exp[63:32] || bus.lo !== exp[31:0]) begin
      errors++;
      $display("FAIL %s op=%0d a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h",
               name, op, a, b, bus.hi, bus.lo, exp[63:32], exp[31:0]);
    end
    checks++;
    if (cyc !== 33 || bus.div_zero !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_lat got cyc=%0d dz=%b busy=%b exp 33 0 0",
               name, cyc, bus.div_zero, bus.busy);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000 ||
        bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL reset got busy=%b done=%b dz=%b hi=%h lo=%h exp 0",
               bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo);
    end
  endtask

  task automatic test_random;
    int cyc;
    int bc;
    logic [31:0] a;
    logic [31:0] b;
    for (int op = 0; op < 4; op++) begin
      for (int i = 0; i < 8; i++) begin
        a = (i < 2) ? 32'($urandom_range(0, 300)) : $urandom;
        b = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
        if (i == 7) b = 32'hFFFF_FFFF - 32'(op);
        if (b == 0) b = 1;
        run_op(2'(op), a, b, cyc, bc);
        check_res("rand", 2'(op), a, b, cyc);
      end
    end
  endtask

  task automatic test_directed;
    int cyc;
    int bc;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bc);
    checks++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h1 ||
        cyc !== 33 || bc !== 33) begin
      errors++;
      $display("FAIL multu_max got hi=%h lo=%h cyc=%0d busy=%0d exp fffffffe 1 33 33",
               bus.hi, bus.lo, cyc, bc);
    end
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, cyc, bc);
    checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_neg got hi=%h lo=%h exp ffffffff ffffffeb",
               bus.hi, bus.lo);
    end
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, cyc, bc);
    checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_neg got hi=%h lo=%h exp ffffffff fffffffd",
               bus.hi, bus.lo);
    end
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bc);
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_ovf got hi=%h lo=%h exp 0 80000000",
               bus.hi, bus.lo);
    end
    run_op(2'b10, 32'd100, 32'd7, cyc, bc);
    checks++;
    if (bus.hi !== 32'd2 || bus.lo !== 32'd14 || cyc !== 33) begin
      errors++;
      $display("FAIL divu_100_7 got hi=%h lo=%h cyc=%0d exp 2 14 33",
               bus.hi, bus.lo, cyc);
    end
  endtask

  task automatic test_div_zero;
    int cyc;
    int bc;
    bus.wdata = 32'h11;
    bus.hi_we = 1'b1;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    bus.wdata = 32'h22;
    bus.lo_we = 1'b1;
    @(posedge clk);
    #1;
    bus.lo_we = 1'b0;
    checks++;
    if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
      errors++;
      $display("FAIL mt_write got hi=%h lo=%h exp 11 22", bus.hi, bus.lo);
    end
    run_op(2'b10, 32'd100, 32'd0, cyc, bc);
    checks++;
    if (cyc !== 1 || bus.div_zero !== 1'b1 ||
        bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
      errors++;
      $display("FAIL divzero got cyc=%0d dz=%b hi=%h lo=%h exp 1 1 11 22",
               cyc, bus.div_zero, bus.hi, bus.lo);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL dz_pulse got done=%b dz=%b exp 0 0",
               bus.done, bus.div_zero);
    end
  endtask

  task automatic test_busy_ignore;
    int cyc;
    bus.op    = 2'b00;
    bus.busA  = 32'd5;
    bus.busB  = 32'd6;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 100) begin
      if (cyc == 5) begin
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.busA  = 32'd9;
        bus.busB  = 32'd3;
        bus.hi_we = 1'b1;
        bus.wdata = 32'hDEAD;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      cyc++;
    end
    checks++;
    if (bus.done !== 1'b1 || cyc !== 33 ||
        bus.hi !== 32'h0 || bus.lo !== 32'd30) begin
      errors++;
      $display("FAIL busy_ignore got done=%b cyc=%0d hi=%h lo=%h exp 1 33 0 1e",
               bus.done, cyc, bus.hi, bus.lo);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    int bc;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    a = $urandom;
    b = $urandom;
    run_op(2'b01, a, b, cyc, bc);
    exp = model(2'b01, a, b);
    // start and MTHI collide in the done cycle: the write must be lost
    bus.hi_we = 1'b1;
    bus.wdata = 32'hBEEF;
    run_op(2'b11, 32'd55, 32'd0, cyc, bc);
    checks++;
    if (cyc !== 1 || bus.div_zero !== 1'b1 ||
        bus.hi !== exp[63:32] || bus.lo !== exp[31:0]) begin
      errors++;
      $display("FAIL b2b got cyc=%0d dz=%b hi=%h lo=%h exp 1 1 %h %h",
               cyc, bus.div_zero, bus.hi, bus.lo, exp[63:32], exp[31:0]);
    end
    a = $urandom;
    b = 32'($urandom_range(1, 1000));
    run_op(2'b10, a, b, cyc, bc);
    check_res("b2b_divu", 2'b10, a, b, cyc);
  endtask

  task automatic test_reset_abort;
    int cyc;
    int seen;
    bus.wdata = 32'h55;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    checks++;
    if (bus.hi !== 32'h55 || bus.lo !== 32'h55) begin
      errors++;
      $display("FAIL both_we got hi=%h lo=%h exp 55 55", bus.hi, bus.lo);
    end
    bus.op    = 2'b11;
    bus.busA  = 32'd1000;
    bus.busB  = 32'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL rst_abort got busy=%b done=%b hi=%h lo=%h exp 0 0 0 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_no_done got %0d active cycles exp 0", seen);
    end
    run_op(2'b00, 32'd3, 32'd4, cyc, seen);
    checks++;
    if (bus.lo !== 32'd12 || bus.hi !== 32'h0 || cyc !== 33) begin
      errors++;
      $display("FAIL post_rst got hi=%h lo=%h cyc=%0d exp 0 c 33",
               bus.hi, bus.lo, cyc);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.busA  = '0;
    bus.busB  = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    test_directed;
    test_div_zero;
    test_random;
    test_busy_ignore;
    test_back_to_back;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer for the pipelined MIPS core; executes MULT, MULTU, DIV and DIVU.
- Produces results one bit per cycle through an internal 33-bit add/subtract step, and owns the architectural HI/LO registers.
- Sits beside the single-cycle ALU in EX. It raises `busy` so the hazard unit stalls the pipeline until `done`.
- Also services MTHI/MTLO writes and drives HI/LO for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width, equal to log2(WIDTH).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- start  in  1  launch operation; sampled only when busy=0
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- busA  in  WIDTH  multiplicand / dividend (rs)
- busB  in  WIDTH  multiplier / divisor (rt)
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight; stall request
- done  out  1  one-cycle completion pulse
- div_zero  out  1  valid with done; divide by zero detected
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-high.
  - Reset forces: state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0.
  - Reset mid-operation aborts the operation. HI/LO clear to 0 and no done pulse is produced.
- States: IDLE, CALC, FIXUP.
- IDLE, on start=1 at edge E0:
  - Latch op and operand sign bits.
  - Load magnitudes: absolute value when op is signed, raw bits when unsigned.
  - counter=0, busy=1, state=CALC.
  - Exception: for DIV/DIVU with busB=0, go directly to FIXUP with the dz flag set. No iterations run.
- CALC: one iteration per edge, E1..E32.
  - Multiply uses shift-add: a 33-bit accumulator adds the multiplicand when the multiplier LSB is 1, then the {acc, multiplier} pair shifts right.
  - Divide uses restoring division: shift {rem, quot} left by 1, trial subtract the divisor, set quot LSB to 1 if the result is non-negative, otherwise restore.
  - counter increments each edge. When counter=WIDTH-1, next state=FIXUP.
- FIXUP, one edge (E33 normally, E1 for divide by zero):
  - Signed multiply: 64-bit product is two's-complement negated when the operand signs differ.
  - Signed divide: quotient is negated when the signs differ. Remainder takes the dividend's sign.
  - Write hi = product[63:32] or remainder; lo = product[31:0] or quotient.
  - Divide by zero: hi/lo unchanged, div_zero=1.
  - done=1 and busy=0 for the cycle after this edge, then state=IDLE.
  - done and div_zero are one-cycle pulses. div_zero is 0 whenever done=0.
- Latency:
  - start sampled at E0; busy is high from E0 to E33; done follows E33. That is 33 cycles.
  - Divide by zero: done follows E1.
- DIV 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0. This is the natural algorithm result; no trap is raised.
- start while busy=1 is ignored; the operation in flight is unaffected.
- hi_we/lo_we:
  - While busy=1, writes are ignored.
  - While busy=0, the register takes wdata at the edge. Both strobes may assert together.
  - If start and hi_we/lo_we are asserted in the same IDLE cycle, start wins and the write is dropped.
- start may be asserted in the done cycle (busy=0); it is accepted as a new E0.
- Operands are sampled only at E0. busA/busB may change afterwards.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done exactly 33 cycles after start; busy high for 33 cycles.
- MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Preload hi=0x11, lo=0x22 via hi_we/lo_we, then DIVU 100 / 0 -> done with div_zero=1 one cycle after start; hi=0x11, lo=0x22 unchanged.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 100 / 7 -> lo=14, hi=2.
- Start MULTU 5x6. At cycle 5 pulse start with new operands and hi_we with wdata=0xDEAD -> both ignored; result hi=0, lo=30.
- Start DIV. Assert rst at cycle 10 -> busy=0, hi=lo=0 immediately, no done pulse. A new MULTU 3x4 then gives lo=12.
